vga_update_sched: RTL and testbench
===================================

VGA_UPDATE_SCHED -- requirements
Module: vga_update_sched

Interface
REQ-001 Parameter COUNTER_BITS, default 10: width of v_count, matching the VGA timing controller.
REQ-002 Parameter V_RES, default 480: first v_count value of vertical blanking.
REQ-003 Parameter DATA_W, default 22: display pattern width, the tail-light word width.
REQ-004 Parameter HOLD_FRAMES, default 4, legal range 0..15: frames skipped after each commit.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk_50MHz  input  1  sole clock, rising edge.
REQ-007 clear  input  1  asynchronous reset, active-low.
REQ-008 v_count  input  COUNTER_BITS  vertical line count from the timing controller.
REQ-009 req_a  input  1  requester A (tail-light FSM) update request, level.
REQ-010 data_a  input  DATA_W  requester A pattern.
REQ-011 req_b  input  1  requester B (overlay/test pattern) update request, level.
REQ-012 data_b  input  DATA_W  requester B pattern.
REQ-013 gnt_a, gnt_b  output  1 each  one-cycle grant pulses.
REQ-014 disp_out  output  DATA_W  committed pattern driven to the bit generator.
REQ-015 frame_tick  output  1  one-cycle pulse at vertical-blank entry.
REQ-016 frame_count  output  8  frames since reset, wraps 255->0.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 vblank SHALL be (v_count >= V_RES), registered into vblank_d; frame_tick SHALL be registered (vblank & ~vblank_d), one cycle wide.
REQ-019 frame_count SHALL increment on every frame_tick cycle, modulo 256.
REQ-020 The FSM SHALL have exactly four states: IDLE, GRANT, COMMIT, HOLD.
REQ-021 IDLE -> GRANT: frame_tick=1 and (req_a|req_b)=1 in the same cycle; otherwise stay in IDLE.
REQ-022 Winner selection SHALL happen on the IDLE->GRANT cycle and be registered.
  - single requester wins outright
  - both requesting: round-robin, the requester not granted last wins
  - after reset, last_grant SHALL be B, so A wins the first tie
REQ-023 In GRANT (one cycle), the winner's gnt SHALL be high, its data SHALL be captured into a shadow register, and last_grant SHALL update; next state COMMIT.
REQ-024 gnt_a and gnt_b SHALL never be high together, and each pulse SHALL be exactly one cycle.
REQ-025 Requesters SHALL hold req and data stable until gnt; data is sampled only in the GRANT cycle, even if req has dropped.
REQ-026 In COMMIT (one cycle), disp_out SHALL load the shadow, visible the following cycle, 3 cycles after frame_tick.
REQ-027 On leaving COMMIT, hold_cnt SHALL load HOLD_FRAMES; next state HOLD if HOLD_FRAMES>0, else IDLE.
REQ-028 In HOLD:
  - each frame_tick decrements hold_cnt
  - the decrement from 1 to 0 transitions to IDLE
  - the frame_tick that ends HOLD SHALL NOT start an arbitration; the next frame_tick does
REQ-029 Requests arriving during GRANT, COMMIT or HOLD SHALL be neither lost nor queued; they are served at the first IDLE frame_tick while still asserted.
REQ-030 disp_out SHALL change only in COMMIT; it is never torn mid-frame.
REQ-031 v_count wrapping to 0 SHALL clear vblank; no tick SHALL be produced on the falling edge.

Reset
REQ-032 clear=0 SHALL immediately force:
  - state=IDLE
  - gnt_a=gnt_b=0, frame_tick=0, busy=0
  - disp_out=0, shadow=0, frame_count=0, hold_cnt=0
  - vblank_d=1, so no spurious tick if reset releases inside blanking
  - last_grant=B
REQ-033 Reset asserted in GRANT or COMMIT SHALL abort the update, leaving disp_out=0 with no grant completed.
REQ-034 After reset deassertion, the first frame_tick SHALL occur on the next 0->1 edge of vblank.

Verification
REQ-035 Single request: req_a=1, data_a=22'h3F, v_count steps 479->480 -> frame_tick 1 cycle later, gnt_a the next cycle, disp_out=22'h3F 3 cycles after frame_tick, busy=1 from GRANT.
REQ-036 Tie fairness: req_a=req_b=1 held across 12 frames, HOLD_FRAMES=0 -> grants alternate A,B,A,B...; gnt_a and gnt_b never overlap.
REQ-037 Hold rate-limit: HOLD_FRAMES=4, req_b held constant -> grants on frames 0,5,10; no grant on frames 1-4 or 6-9.
REQ-038 Mid-operation reset: clear=0 in the GRANT cycle -> gnt drops the same cycle, disp_out=0, and an A-versus-B tie after release grants A.
REQ-039 Reset released with v_count=500 -> no frame_tick until v_count wraps to 0 and reaches 480 again; frame_count=1 after that tick.
REQ-040 Wrap: 256 frame_ticks -> frame_count returns to 0.

Source files
------------

// File: rtl/vga_update_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_update_sched                                            |
// | Description : Frame-synchronous display update scheduler. Arbitrates two   |
// |               pattern requesters at vertical-blank entry (round-robin on a |
// |               tie). It commits the winner's pattern during blanking, then  |
// |               rate-limits further updates by HOLD_FRAMES frames.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vga_update_sched #(
  parameter int COUNTER_BITS = 10,
  parameter int V_RES        = 480,
  parameter int DATA_W       = 22,
  parameter int HOLD_FRAMES  = 4
) (
  input  logic                    clk_50MHz,
  input  logic                    clear,
  input  logic [COUNTER_BITS-1:0] v_count,
  input  logic                    req_a,
  input  logic [DATA_W-1:0]       data_a,
  input  logic                    req_b,
  input  logic [DATA_W-1:0]       data_b,
  output logic                    gnt_a,
  output logic                    gnt_b,
  output logic [DATA_W-1:0]       disp_out,
  output logic                    frame_tick,
  output logic [7:0]              frame_count,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_COMMIT = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam logic [3:0]              C_HOLD  = 4'(HOLD_FRAMES);
  localparam logic [COUNTER_BITS-1:0] C_V_RES = COUNTER_BITS'(V_RES);

  state_t              r_state;
  state_t              w_next;
  logic                w_vblank;
  logic                r_vblank_d;
  logic                r_tick;
  logic [7:0]          r_frame_cnt;
  logic                r_win_b;     // registered winner: 1 = B, 0 = A
  logic                r_last_b;    // requester granted most recently: 1 = B
  logic                w_win_b;
  logic                w_arb;
  logic [DATA_W-1:0]   r_shadow;
  logic [DATA_W-1:0]   r_disp;
  logic [3:0]          r_hold_cnt;
  logic                w_gnt_a;
  logic                w_gnt_b;

  assign w_vblank = (v_count >= C_V_RES);

  // Tie goes to whoever was not granted last; a lone requester always wins.
  assign w_win_b = (req_a & req_b) ? ~r_last_b : req_b;
  assign w_arb   = r_tick & (req_a | req_b);

  // Blanking-entry edge detector and frame counter. vblank_d resets high so a
  // release inside blanking waits for the next genuine 0->1 edge.
  always_ff @(posedge clk_50MHz or negedge clear) begin
    if (!clear) begin
      r_vblank_d  <= 1'b1;
      r_tick      <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_vblank_d <= w_vblank;
      r_tick     <= w_vblank & ~r_vblank_d;
      if (r_tick) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_50MHz or negedge clear) begin
    if (!clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and grant decode; grants come straight from state so a reset
  // in GRANT removes them immediately.
  always_comb begin
    w_next  = r_state;
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_arb) begin
          w_next = S_GRANT;
        end
      end
      S_GRANT: begin
        w_gnt_a = ~r_win_b;
        w_gnt_b = r_win_b;
        w_next  = S_COMMIT;
      end
      S_COMMIT: begin
        w_next = (C_HOLD != 4'd0) ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        // The tick that empties the hold counter does not also arbitrate.
        if (r_tick && (r_hold_cnt <= 4'd1)) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Winner latch, shadow capture, display commit and hold-off counter.
  always_ff @(posedge clk_50MHz or negedge clear) begin
    if (!clear) begin
      r_win_b    <= 1'b0;
      r_last_b   <= 1'b1;
      r_shadow   <= '0;
      r_disp     <= '0;
      r_hold_cnt <= 4'd0;
    end else begin
      if ((r_state == S_IDLE) && w_arb) begin
        r_win_b <= w_win_b;
      end
      if (r_state == S_GRANT) begin
        r_shadow <= r_win_b ? data_b : data_a;
        r_last_b <= r_win_b;
      end
      if (r_state == S_COMMIT) begin
        r_disp     <= r_shadow;
        r_hold_cnt <= C_HOLD;
      end
      if ((r_state == S_HOLD) && r_tick && (r_hold_cnt != 4'd0)) begin
        r_hold_cnt <= r_hold_cnt - 4'd1;
      end
    end
  end

  assign gnt_a       = w_gnt_a;
  assign gnt_b       = w_gnt_b;
  assign disp_out    = r_disp;
  assign frame_tick  = r_tick;
  assign frame_count = r_frame_cnt;
  assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vga_update_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vga_update_sched                                         |
// | Description : Directed self-checking bench for vga_update_sched. Two      |
// |               instances share stimulus: HOLD_FRAMES=4 and HOLD_FRAMES=0.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_vga_update_sched;

  localparam int DW = 22;
  localparam int CB = 10;

  logic          clk;
  logic          clear;
  logic [CB-1:0] v_count;
  logic          req_a, req_b;
  logic [DW-1:0] data_a, data_b;

  logic          gnt_a4, gnt_b4, tick4, busy4;
  logic [DW-1:0] disp4;
  logic [7:0]    fc4;
  logic          gnt_a0, gnt_b0, tick0, busy0;
  logic [DW-1:0] disp0;
  logic [7:0]    fc0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  vga_update_sched #(.COUNTER_BITS(CB), .V_RES(480), .DATA_W(DW), .HOLD_FRAMES(4)) u_dut (
    .clk_50MHz(clk), .clear(clear), .v_count(v_count),
    .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
    .gnt_a(gnt_a4), .gnt_b(gnt_b4), .disp_out(disp4),
    .frame_tick(tick4), .frame_count(fc4), .busy(busy4)
  );

  vga_update_sched #(.COUNTER_BITS(CB), .V_RES(480), .DATA_W(DW), .HOLD_FRAMES(0)) u_dut_h0 (
    .clk_50MHz(clk), .clear(clear), .v_count(v_count),
    .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
    .gnt_a(gnt_a0), .gnt_b(gnt_b0), .disp_out(disp0),
    .frame_tick(tick0), .frame_count(fc0), .busy(busy0)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Grant / tick monitor, sampled on the falling edge.
  int unsigned m_ga4 = 0, m_gb4 = 0, m_ga0 = 0, m_gb0 = 0;
  int unsigned m_ticks = 0, m_overlap = 0, m_wide = 0;
  logic [31:0] m_seq0 = '0, m_seq4 = '0;
  logic        p_ga4 = 1'b0, p_gb4 = 1'b0, p_ga0 = 1'b0, p_gb0 = 1'b0;

  always @(negedge clk) begin
    if (gnt_a4) m_ga4++;
    if (gnt_b4) m_gb4++;
    if (gnt_a0) m_ga0++;
    if (gnt_b0) m_gb0++;
    if (gnt_a4 || gnt_b4) m_seq4 = {m_seq4[30:0], gnt_b4};
    if (gnt_a0 || gnt_b0) m_seq0 = {m_seq0[30:0], gnt_b0};
    if ((gnt_a4 && gnt_b4) || (gnt_a0 && gnt_b0)) m_overlap++;
    if ((gnt_a4 && p_ga4) || (gnt_b4 && p_gb4) || (gnt_a0 && p_ga0) || (gnt_b0 && p_gb0)) m_wide++;
    if (tick4) m_ticks++;
    p_ga4 = gnt_a4; p_gb4 = gnt_b4; p_ga0 = gnt_a0; p_gb0 = gnt_b0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [CB-1:0] vc);
    clear   = 1'b0;
    v_count = vc;
    req_a   = 1'b0;
    req_b   = 1'b0;
    repeat (2) cycle();
    clear = 1'b1;
    cycle();
  endtask

  // One frame: line 479, then six blanking cycles at 480, then back to 0.
  task automatic frame();
    v_count = 10'd479;
    cycle();
    v_count = 10'd480;
    repeat (6) cycle();
    v_count = 10'd0;
    repeat (3) cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  int unsigned s_a, s_b, s_a0, s_b0, s_a4, s_b4, s_t;

  initial begin
    clear = 1'b0; v_count = '0; req_a = 1'b0; req_b = 1'b0;
    data_a = '0; data_b = '0;

    // Reset state
    repeat (2) cycle();
    check_eq("rst_busy",  {30'd0, busy4, busy0}, 32'h0);
    check_eq("rst_gnt",   {28'd0, gnt_a4, gnt_b4, gnt_a0, gnt_b0}, 32'h0);
    check_eq("rst_disp",  disp4, 32'h0);
    check_eq("rst_fc",    fc4, 32'h0);
    check_eq("rst_tick",  tick4, 32'h0);
    clear = 1'b1;
    cycle();

    // Single request: timing from tick to grant to visible commit
    req_a = 1'b1; data_a = 22'h3F; v_count = 10'd479;
    cycle();
    v_count = 10'd480;
    cycle();
    check_eq("sr_tick",     tick4, 32'h1);
    check_eq("sr_gnt_early", gnt_a4, 32'h0);
    cycle();
    check_eq("sr_tick_1cyc", tick4, 32'h0);
    check_eq("sr_gnt_a",    gnt_a4, 32'h1);
    check_eq("sr_gnt_b",    gnt_b4, 32'h0);
    check_eq("sr_busy_g",   busy4, 32'h1);
    req_a = 1'b0;
    cycle();
    check_eq("sr_gnt_off",  gnt_a4, 32'h0);
    check_eq("sr_busy_c",   busy4, 32'h1);
    check_eq("sr_disp_c",   disp4, 32'h0);
    cycle();
    check_eq("sr_disp4",    disp4, 32'h3F);
    check_eq("sr_disp0",    disp0, 32'h3F);
    check_eq("sr_busy_hold", busy4, 32'h1);
    check_eq("sr_busy_h0",  busy0, 32'h0);
    check_eq("sr_fc",       fc4, 32'h1);
    v_count = 10'd0;
    repeat (3) cycle();

    // Tie fairness over 12 frames
    do_reset(10'd0);
    data_a = 22'h0AAAAA; data_b = 22'h155555;
    req_a = 1'b1; req_b = 1'b1;
    s_a0 = m_ga0; s_b0 = m_gb0; s_a4 = m_ga4; s_b4 = m_gb4;
    repeat (12) frame();
    check_eq("tie_cnt0",  (m_ga0 - s_a0) + (m_gb0 - s_b0), 32'd12);
    check_eq("tie_seq0",  m_seq0[11:0], 32'h555);
    check_eq("tie_cnt4",  (m_ga4 - s_a4) + (m_gb4 - s_b4), 32'd3);
    check_eq("tie_seq4",  m_seq4[2:0], 32'h2);
    check_eq("tie_disp0", disp0, 32'h155555);
    check_eq("tie_disp4", disp4, 32'h0AAAAA);
    req_a = 1'b0; req_b = 1'b0;

    // Hold rate-limit with req_b held
    do_reset(10'd0);
    data_b = 22'h2D; req_b = 1'b1;
    for (int f = 0; f < 11; f++) begin
      s_b = m_gb4;
      frame();
      check_eq($sformatf("hold_f%0d", f), m_gb4 - s_b, (f % 5 == 0) ? 32'd1 : 32'd0);
    end
    check_eq("hold_disp", disp4, 32'h2D);
    check_eq("hold_a_none", m_ga4 - s_a4 - 2, 32'd0);
    req_b = 1'b0;

    // Reset asserted during GRANT
    do_reset(10'd0);
    data_a = 22'h01234; data_b = 22'h05678;
    req_a = 1'b1; req_b = 1'b1;
    v_count = 10'd479;
    cycle();
    v_count = 10'd480;
    cycle();
    cycle();
    check_eq("mr_gnt_pre", gnt_a4, 32'h1);
    #1 clear = 1'b0;
    #1;
    check_eq("mr_gnt_drop", {28'd0, gnt_a4, gnt_b4, gnt_a0, gnt_b0}, 32'h0);
    check_eq("mr_busy",     {30'd0, busy4, busy0}, 32'h0);
    cycle();
    check_eq("mr_disp",     {disp4[15:0], disp0[15:0]}, 32'h0);
    clear = 1'b1;
    v_count = 10'd0;
    repeat (2) cycle();
    s_a = m_ga4; s_b = m_gb4;
    frame();
    check_eq("mr_tie_a",    m_ga4 - s_a, 32'd1);
    check_eq("mr_tie_b",    m_gb4 - s_b, 32'd0);
    check_eq("mr_disp_a",   disp4, 32'h01234);
    req_a = 1'b0; req_b = 1'b0;

    // Release inside blanking
    do_reset(10'd500);
    s_t = m_ticks;
    repeat (5) cycle();
    check_eq("rb_no_tick",  m_ticks - s_t, 32'd0);
    check_eq("rb_fc0",      fc4, 32'h0);
    v_count = 10'd0;
    repeat (3) cycle();
    check_eq("rb_fall_none", m_ticks - s_t, 32'd0);
    frame();
    check_eq("rb_one_tick", m_ticks - s_t, 32'd1);
    check_eq("rb_fc1",      fc4, 32'h1);

    // frame_count wrap
    do_reset(10'd0);
    repeat (255) frame();
    check_eq("wrap_255",    fc4, 32'hFF);
    frame();
    check_eq("wrap_0",      fc4, 32'h0);
    check_eq("wrap_0_h0",   fc0, 32'h0);

    check_eq("no_overlap",  m_overlap, 32'd0);
    check_eq("no_wide",     m_wide, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
